// File: rtl/frame_buffer_pingpong.sv
// Double-buffered (ping-pong) pixel frame buffer.
// Port A (producer) writes with per-channel masks into the back page; port B (display)
// reads the front page with one cycle of latency. A swap requested with swap_req is
// applied on the next frame_sync while idle. After reset the whole store is zeroed one
// word per cycle; clear_req zeroes only the back page the same way.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wr_en_a/wr_addr_a/wr_data_a   port A pixel write into the back page
//   wr_mask_a                     per-channel enable, bit0 = least significant channel
//   rd_en_b/rd_addr_b             port B pixel read from the front page
//   rd_data_b/rd_valid_b          read result, valid one cycle after rd_en_b
//   swap_req, frame_sync          page-swap request and display frame boundary pulses
//   clear_req                     zero the back page
//   busy                          a clear sweep is running
//   swap_pending                  swap requested but not yet applied
//   front_page                    page index currently shown on port B
//   addr_err                      sticky out-of-range access flag
module frame_buffer_pingpong #(
  parameter int unsigned WIDTH   = 96,
  parameter int unsigned HEIGHT  = 48,
  parameter int unsigned BPP     = 12,
  parameter int unsigned BPC     = 4,
  parameter int unsigned CHAINED = 1,
  parameter int unsigned PAGES   = 2,
  localparam int unsigned DEPTH  = CHAINED * WIDTH * HEIGHT,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned PW     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en_a,
  input  logic [AW-1:0]  wr_addr_a,
  input  logic [BPP-1:0] wr_data_a,
  input  logic [2:0]     wr_mask_a,
  input  logic           rd_en_b,
  input  logic [AW-1:0]  rd_addr_b,
  output logic [BPP-1:0] rd_data_b,
  output logic           rd_valid_b,
  input  logic           swap_req,
  input  logic           frame_sync,
  input  logic           clear_req,
  output logic           busy,
  output logic           swap_pending,
  output logic [PW-1:0]  front_page,
  output logic           addr_err
);

  localparam int unsigned WORDS = PAGES * DEPTH;
  localparam int unsigned IW    = $clog2(WORDS);

  localparam logic [1:0] StClearAll  = 2'd0;
  localparam logic [1:0] StIdle      = 2'd1;
  localparam logic [1:0] StClearBack = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [PW-1:0]  back_page;
  logic           wr_in_range, rd_in_range;
  logic           clr_last, clr_fire, wr_fire, do_swap;
  logic [IW-1:0]  wr_idx, rd_idx, clr_idx;
  logic [BPP-1:0] mem [WORDS];

  // With one page the producer and display share page 0.
  assign back_page   = (PAGES == 2) ? (front_page ^ PW'(1)) : '0;
  assign wr_in_range = 32'(wr_addr_a) < DEPTH;
  assign rd_in_range = 32'(rd_addr_b) < DEPTH;

  assign wr_idx  = IW'(32'(back_page) * DEPTH + 32'(wr_addr_a));
  assign rd_idx  = IW'(32'(front_page) * DEPTH + 32'(rd_addr_b));
  assign clr_idx = (state_q == StClearAll) ? clr_cnt_q
                                           : IW'(32'(back_page) * DEPTH + 32'(clr_cnt_q));

  assign clr_last = (state_q == StClearAll) ? (32'(clr_cnt_q) == WORDS - 1)
                                            : (32'(clr_cnt_q) == DEPTH - 1);

  assign busy     = (state_q != StIdle);
  assign clr_fire = !rst && busy;
  assign wr_fire  = !rst && (state_q == StIdle) && wr_en_a && wr_in_range;
  // A swap arriving with the frame boundary is taken immediately, no pending cycle.
  assign do_swap  = (PAGES == 2) && (state_q == StIdle) && frame_sync &&
                    (swap_pending || swap_req);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      StClearAll, StClearBack: begin
        if (clr_last) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (clear_req) begin
          state_d   = StClearBack;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = StClearAll;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StClearAll;
      clr_cnt_q    <= '0;
      front_page   <= '0;
      swap_pending <= 1'b0;
      addr_err     <= 1'b0;
      rd_data_b    <= '0;
      rd_valid_b   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;

      if (do_swap) begin
        front_page   <= front_page ^ PW'(1);
        swap_pending <= 1'b0;
      end else if (swap_req && (PAGES == 2)) begin
        swap_pending <= 1'b1;
      end

      if ((wr_en_a && !wr_in_range) || (rd_en_b && !rd_in_range)) begin
        addr_err <= 1'b1;
      end

      // Non-blocking read of mem gives read-before-write on a shared word.
      rd_valid_b <= rd_en_b;
      if (rd_en_b) begin
        rd_data_b <= (rd_in_range && (state_q != StClearAll)) ? mem[rd_idx] : '0;
      end
    end
  end

  // Storage: clear sweep and producer writes never coincide (writes drop while busy).
  always_ff @(posedge clk) begin
    if (clr_fire) begin
      mem[clr_idx] <= '0;
    end else if (wr_fire) begin
      for (int c = 0; c < 3; c++) begin
        if (wr_mask_a[c]) begin
          mem[wr_idx][c*BPC +: BPC] <= wr_data_a[c*BPC +: BPC];
        end
      end
    end
  end

endmodule

// File: doc/frame_buffer_pingpong.md
FRAME_BUFFER_PINGPONG -- requirements
Module: frame_buffer_pingpong

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 96, panel width in pixels.
- HEIGHT, 48, panel height in pixels.
- BPP, 12, bits per pixel.
- BPC, 4, bits per colour channel; BPP = 3*BPC.
- CHAINED, 1, number of chained panels.
- PAGES, 2, page count, 1 or 2 only.
- Derived: DEPTH = CHAINED*WIDTH*HEIGHT; AW = clog2(DEPTH); PW = clog2(PAGES) min 1.
REQ-002 Clock and reset: clk, reset rst, synchronous, active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- wr_en_a, in, 1, write request, port A (producer, writes back page).
- wr_addr_a, in, AW, pixel address, port A.
- wr_data_a, in, BPP, pixel data, port A.
- wr_mask_a, in, 3, per-channel write enable; bit0 = bits[BPC-1:0], bit2 = MS channel.
- rd_en_b, in, 1, read request, port B (display, reads front page).
- rd_addr_b, in, AW, pixel address, port B.
- rd_data_b, out, BPP, read data, port B.
- rd_valid_b, out, 1, rd_data_b valid.
- swap_req, in, 1, request page swap (pulse).
- frame_sync, in, 1, display frame boundary (pulse).
- clear_req, in, 1, clear back page (pulse).
- busy, out, 1, clear in progress.
- swap_pending, out, 1, swap requested, not yet applied.
- front_page, out, PW, page index read by port B.
- addr_err, out, 1, sticky out-of-range access flag.

Function
REQ-004 Storage: PAGES*DEPTH words of BPP bits; physical index = page*DEPTH + addr.
REQ-005 FSM states: CLEAR_ALL, IDLE, CLEAR_BACK.
- rst -> CLEAR_ALL.
- CLEAR_ALL -> IDLE after zeroing all PAGES*DEPTH words, one per cycle.
- IDLE + clear_req -> CLEAR_BACK.
- CLEAR_BACK -> IDLE after zeroing the DEPTH back-page words.
REQ-006 busy = 1 in CLEAR_ALL and CLEAR_BACK, 0 in IDLE; busy falls the cycle after the last word is written.
REQ-007 While busy: port A writes are dropped silently; clear_req is ignored.
REQ-008 Port A write (IDLE, wr_en_a=1, wr_addr_a<DEPTH): updates only the channels enabled by wr_mask_a in back page (front_page^1 when PAGES=2, page 0 when PAGES=1); visible on next clock.
REQ-009 Port B read (rd_en_b=1): rd_data_b = front-page word, 1-cycle latency; rd_valid_b pulses 1 with it; rd_data_b holds its value when rd_en_b=0.
REQ-010 Same physical word written by A and read by B in the same cycle (PAGES=1 only): B returns old data (read-before-write).
REQ-011 Port B reads during CLEAR_ALL return 0 with rd_valid_b=1; during CLEAR_BACK they return front-page data normally.
REQ-012 Address >= DEPTH on any enabled access: addr_err sets, stays set until rst; the write is dropped; the read returns 0 with rd_valid_b=1.
REQ-013 Swap: swap_req sets swap_pending. On a cycle with frame_sync=1, swap_pending (or swap_req in that same cycle) and state IDLE: front_page toggles on the next clock and swap_pending clears.
REQ-014 Swap with frame_sync while busy: remains pending and is applied at the first frame_sync after busy falls.
REQ-015 PAGES=1: swap_req is ignored; swap_pending and front_page stay 0.
REQ-016 The port-A page selection follows front_page from the same clock edge the swap takes effect; there is no write to the page being displayed.

Reset
REQ-017 rst (synchronous) forces:
- rd_data_b=0, rd_valid_b=0.
- front_page=0, swap_pending=0, addr_err=0.
- busy=1 on the next clock; state CLEAR_ALL, clear counter 0.
REQ-018 rst asserted mid-clear or mid-operation restarts CLEAR_ALL from word 0; pending swap is discarded.

Verification
REQ-019 Defaults, rst 1 cycle -> busy=1 for exactly 4608*2 cycles, then 0; every read of front page then returns 0.
REQ-020 Write 0xABC at addr 5, mask 3'b101, over existing 0x123 -> after swap+frame_sync, read addr 5 returns 0xA2C one cycle after rd_en_b.
REQ-021 swap_req at cycle 10, frame_sync at cycle 20 -> swap_pending=1 for cycles 11-20, front_page 0->1 at cycle 21; swap_req and frame_sync together -> toggle on the next clock.
REQ-022 Write to addr 4608 and read addr 5000 -> addr_err=1 sticky, memory unchanged, read data 0 with rd_valid_b=1.
REQ-023 clear_req then swap_req+frame_sync during CLEAR_BACK -> swap deferred to the next frame_sync after busy=0; writes issued during clear absent afterward.
REQ-024 PAGES=1, simultaneous write 0x555/read addr 7 holding 0x111 -> read returns 0x111, next read 0x555.
